// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states, flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative W-step shift-add unsigned multiplier; done marks the cycle whose step is the last.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  logic           run;
  logic [SW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  // product is the accumulator value after the final step, valid while done is high
  assign done     = run && (cnt == SW'(W - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops write the output registers at accept, MUL runs iteratively.
// state   | meaning
// ST_IDLE | ready for a request (subject to output backpressure)
// ST_MUL  | multiplier stepping, input port closed
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  alu_state_e     state;
  alu_op_e        op;
  alu_flags_t     flags_q;
  alu_flags_t     flags_d;
  logic [W-1:0]   res_d;
  logic [W:0]     sum_add;
  logic [W:0]     sum_sub;
  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] product;

  assign op        = alu_op_e'(opcode);
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  assign carry = flags_q.carry;
  assign zero  = flags_q.zero;
  assign neg   = flags_q.neg;
  assign ovf   = flags_q.ovf;

  // carry out of a + ~b + 1 is the no-borrow indication
  assign sum_add = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (op)
      OP_ADD: begin
        res_d         = sum_add[W-1:0];
        flags_d.carry = sum_add[W];
        flags_d.ovf   = (a[W-1] == b[W-1]) && (sum_add[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res_d         = sum_sub[W-1:0];
        flags_d.carry = sum_sub[W];
        flags_d.ovf   = (a[W-1] != b[W-1]) && (sum_sub[W-1] != a[W-1]);
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_SHL:  res_d = a << b[SW-1:0];
      OP_SHR:  res_d = a >> b[SW-1:0];
      default: res_d = '0;
    endcase
    flags_d.zero = (res_d == '0);
    flags_d.neg  = res_d[W-1];
  end

  alu_mul_iter #(.W(W), .SW(SW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags_q   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              result    <= res_d;
              result_hi <= '0;
              flags_q   <= flags_d;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result    <= product[W-1:0];
            result_hi <= product[2*W-1:W];
            flags_q   <= '{carry: |product[2*W-1:W], zero: (product == '0),
                           neg: product[W-1], ovf: 1'b0};
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         ovf;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int res;
    int hi;
    int c;
    int z;
    int n;
    int v;
  } exp_t;

  always #5 clk = ~clk;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  function automatic exp_t ref_op(input int op, input int x, input int y, input int ci);
    exp_t e;
    int   full;
    int   sdiff;
    e = '{default: 0};
    case (op)
      0: begin
        full  = x + y + ci;
        e.res = full % MOD;
        e.c   = full / MOD;
        sdiff = to_signed(x) + to_signed(y) + ci;
        e.v   = (sdiff >= HALF || sdiff < -HALF) ? 1 : 0;
      end
      1: begin
        e.res = (x - y + MOD) % MOD;
        e.c   = (x >= y) ? 1 : 0;
        sdiff = to_signed(x) - to_signed(y);
        e.v   = (sdiff >= HALF || sdiff < -HALF) ? 1 : 0;
      end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: e.res = (x * (1 << (y % W))) % MOD;
      6: e.res = x / (1 << (y % W));
      default: begin
        full  = x * y;
        e.res = full % MOD;
        e.hi  = full / MOD;
        e.c   = (e.hi != 0) ? 1 : 0;
      end
    endcase
    e.z = (e.res == 0 && e.hi == 0) ? 1 : 0;
    e.n = (e.res >= HALF) ? 1 : 0;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".result"},    result,    e.res);
    chk({tag, ".result_hi"}, result_hi, e.hi);
    chk({tag, ".carry"},     carry,     e.c);
    chk({tag, ".zero"},      zero,      e.z);
    chk({tag, ".neg"},       neg,       e.n);
    chk({tag, ".ovf"},       ovf,       e.v);
  endtask

  task automatic drive(input int op, input int x, input int y, input int ci);
    in_valid = 1'b1;
    opcode   = op[2:0];
    a        = x[W-1:0];
    b        = y[W-1:0];
    cin      = ci[0];
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".drained"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  task automatic run_single(input int op, input int x, input int y, input int ci, input string tag);
    exp_t e;
    e = ref_op(op, x, y, ci);
    @(negedge clk);
    out_ready = 1'b0;
    drive(op, x, y, ci);
    chk({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    @(negedge clk);
    chk({tag, ".out_valid"}, out_valid, 1);
    check_out(tag, e);
    drain(tag);
  endtask

  task automatic run_mul(input int x, input int y, input string tag);
    exp_t e;
    e = ref_op(7, x, y, 0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(7, x, y, 0);
    chk({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    for (int cyc = 1; cyc <= W; cyc++) begin
      // keep requesting with scrambled inputs; none may be accepted or leak into the product
      drive(int'($urandom_range(0, 7)), int'($urandom), int'($urandom), 0);
      @(negedge clk);
      chk({tag, ".busy_in_ready"}, in_ready, 0);
      chk({tag, ".busy_out_valid"}, out_valid, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".out_valid"}, out_valid, 1);
    check_out(tag, e);
    drain(tag);
  endtask

  initial begin
    exp_t e_first;
    exp_t e_second;
    exp_t stream_exp[16];
    int   sop;
    int   sx;
    int   sy;
    int   sc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 3'd0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.result_hi", result_hi, 0);
    chk("rst.flags", {carry, zero, neg, ovf}, 0);
    chk("rst.in_ready", in_ready, 1);
    rst_n = 1'b1;

    run_single(0, 'hFF, 'h01, 0, "add_ff_01");
    run_single(1, 'h80, 'h01, 0, "sub_80_01");
    run_single(1, 'h01, 'h02, 0, "sub_01_02");
    run_single(0, 'h7F, 'h00, 1, "add_cin_ovf");
    run_single(5, 'h5A, 'h00, 0, "shl_by_0");
    run_single(6, 'hA5, 'h08, 0, "shr_masked_0");
    run_single(5, 'h81, 'h0F, 0, "shl_by_7");
    run_single(6, 'h81, 'h07, 0, "shr_by_7");
    run_mul('hFF, 'hFF, "mul_ff_ff");
    run_mul('h00, 'h5C, "mul_zero");

    // backpressure: XOR result held while a new AND request waits
    e_first  = ref_op(4, 'h3C, 'hA5, 0);
    e_second = ref_op(2, 'hF0, 'h3C, 0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(4, 'h3C, 'hA5, 0);
    @(posedge clk);
    #1;
    drive(2, 'hF0, 'h3C, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp.out_valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      check_out("bp.xor", e_first);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp.next_valid", out_valid, 1);
    check_out("bp.and", e_second);
    drain("bp");

    // streaming: one random non-MUL op per cycle with the consumer always ready
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      sop = int'($urandom_range(0, 6));
      sx  = int'($urandom_range(0, MOD - 1));
      sy  = int'($urandom_range(0, MOD - 1));
      sc  = int'($urandom_range(0, 1));
      stream_exp[i] = ref_op(sop, sx, sy, sc);
      drive(sop, sx, sy, sc);
      chk("stream.in_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      chk("stream.out_valid", out_valid, 1);
      check_out($sformatf("stream%0d", i), stream_exp[i]);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("stream.drained", out_valid, 0);
    out_ready = 1'b0;

    repeat (6) run_single(int'($urandom_range(0, 6)), int'($urandom_range(0, MOD - 1)),
                          int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 1)), "rand_op");
    repeat (3) run_mul(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)), "rand_mul");

    // reset three cycles into a MUL aborts it with outputs cleared at once
    run_single(0, 'hFF, 'h01, 0, "pre_rst_add");
    @(negedge clk);
    drive(7, 'hFF, 'hFF, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.result", result, 0);
    chk("midrst.result_hi", result_hi, 0);
    chk("midrst.flags", {carry, zero, neg, ovf}, 0);
    chk("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      chk("midrst.no_stray", out_valid, 0);
    end
    run_single(0, 3, 4, 0, "post_rst_add");
    chk("post_rst.direct", result, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
